// File: rtl/rr_arbiter4_pkg.sv
// Shared constants, state encoding and grant payload for the 4-way round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    // IDLE: no owner, arbitration runs. GRANT: exactly one owner holds the resource.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Registered grant payload driven to the top-level outputs.
    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } grant_t;

    localparam grant_t GRANT_NONE = '{gnt: '0, idx: '0, valid: 1'b0};

endpackage : rr_arbiter4_pkg

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set req bit at or after ptr, searching upward
// with wrap 3->0.
//   req  : request vector
//   ptr  : index with highest priority this round
//   pick : one-hot winner (zero when no request)
//   idx  : binary winner index (zero when no request)
//   any  : at least one request present
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Walk the four candidates in priority order; the 2-bit add gives the wrap.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!any && req[cand]) begin
                any        = 1'b1;
                idx        = cand;
                pick[cand] = 1'b1;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant, a bounded
// hold time per owner and one dead cycle between consecutive grants.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       : request vector, bit i = requester i
//   done      : current owner releases (ignored with no owner)
//   gnt       : registered one-hot grant
//   gnt_idx   : registered binary index of the owner
//   gnt_valid : registered, high while a grant is held
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX_VAL = {HOLD_W{1'b1}};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    grant_t           out_q, out_d;

    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             hold_expired;
    logic             release_now;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // The owner index is the registered gnt_idx; a limit of zero never expires.
    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
    assign release_now  = done || !req[out_q.idx] || hold_expired;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                out_d  = GRANT_NONE;
                hold_d = '0;
                if (pick_any) begin
                    state_d     = GRANT;
                    out_d.gnt   = pick;
                    out_d.idx   = pick_idx;
                    out_d.valid = 1'b1;
                    hold_d      = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    out_d   = GRANT_NONE;
                    ptr_d   = out_q.idx + IDX_W'(1);
                    hold_d  = '0;
                end else if (hold_q != HOLD_MAX_VAL) begin
                    // Saturate so an unlimited hold never wraps the counter.
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = GRANT_NONE;
                hold_d  = '0;
            end
        endcase
    end

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            out_q   <= GRANT_NONE;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
        end
    end

    assign gnt       = out_q.gnt;
    assign gnt_idx   = out_q.idx;
    assign gnt_valid = out_q.valid;

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: a cycle-by-cycle vector table plus
// hand-written hold-limit and mid-grant reset sequences.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt,  gnt0;
    logic [1:0] gnt_idx, gnt_idx0;
    logic       gnt_valid, gnt_valid0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    rr_arbiter4 #(.MAX_HOLD(0)) dut_nolimit (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt0), .gnt_idx(gnt_idx0), .gnt_valid(gnt_valid0)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                                input logic [3:0] eg, input logic [1:0] ei,
                                input logic ev, input string nm);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d;
        v.gnt = eg; v.idx = ei; v.valid = ev; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm,
                         input logic [3:0] g, input logic [1:0] i, input logic v,
                         input logic [3:0] eg, input logic [1:0] ei, input logic ev);
        tests++;
        if (g !== eg || i !== ei || v !== ev) begin
            failed++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
                     nm, g, i, v, eg, ei, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic d);
        rst = r; req = rq; done = d;
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;

        // Each row: inputs held over one edge, expected outputs just after it.
        add(1, 4'b0000, 0, 4'b0000, 0, 0, "reset");
        add(0, 4'b1111, 0, 4'b0001, 0, 1, "s1_g0");
        add(0, 4'b1111, 1, 4'b0000, 0, 0, "s1_dead0");
        add(0, 4'b1111, 0, 4'b0010, 1, 1, "s1_g1");
        add(0, 4'b1111, 1, 4'b0000, 0, 0, "s1_dead1");
        add(0, 4'b1111, 0, 4'b0100, 2, 1, "s1_g2");
        add(0, 4'b1111, 1, 4'b0000, 0, 0, "s1_dead2");
        add(0, 4'b1111, 0, 4'b1000, 3, 1, "s1_g3");
        add(0, 4'b1111, 1, 4'b0000, 0, 0, "s1_dead3");
        add(0, 4'b1111, 0, 4'b0001, 0, 1, "s1_g0_again");
        add(0, 4'b1111, 1, 4'b0000, 0, 0, "s1_dead4");
        add(0, 4'b0000, 1, 4'b0000, 0, 0, "s6_done_idle");
        add(0, 4'b0000, 0, 4'b0000, 0, 0, "s6_idle");
        add(0, 4'b1111, 0, 4'b0010, 1, 1, "s6_ptr_kept");
        add(0, 4'b0010, 0, 4'b0010, 1, 1, "hold_owner_only");
        add(0, 4'b1111, 0, 4'b0010, 1, 1, "nonowner_ignored");
        add(0, 4'b0000, 0, 4'b0000, 0, 0, "drop_req_release");
        add(1, 4'b1111, 0, 4'b0000, 0, 0, "reset_over_arb");
        add(0, 4'b0100, 0, 4'b0100, 2, 1, "s2_grant2");
        add(0, 4'b0000, 0, 4'b0000, 0, 0, "s2_release");
        add(0, 4'b1001, 0, 4'b1000, 3, 1, "s4_g3");
        add(0, 4'b0001, 1, 4'b0000, 0, 0, "s4_double_release");
        add(0, 4'b1001, 0, 4'b0001, 0, 1, "s4_ptr_wrapped");
        add(0, 4'b0000, 0, 4'b0000, 0, 0, "s4_release");
        add(0, 4'b0001, 0, 4'b0001, 0, 1, "wrap_search");
        add(0, 4'b0000, 0, 4'b0000, 0, 0, "wrap_release");

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].req, vecs[k].done);
            step();
            check(vecs[k].name, gnt, gnt_idx, gnt_valid,
                  vecs[k].gnt, vecs[k].idx, vecs[k].valid);
        end

        // Hold limit: eight granted cycles, one dead cycle, regrant to 0.
        drive(1, 4'b0000, 0);
        step();
        check("s3_reset", gnt, gnt_idx, gnt_valid, 4'b0000, 0, 0);
        drive(0, 4'b0001, 0);
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("s3_hold%0d", c + 1), gnt, gnt_idx, gnt_valid, 4'b0001, 0, 1);
            check($sformatf("nolimit_hold%0d", c + 1), gnt0, gnt_idx0, gnt_valid0, 4'b0001, 0, 1);
        end
        step();
        check("s3_dead", gnt, gnt_idx, gnt_valid, 4'b0000, 0, 0);
        check("nolimit_keeps", gnt0, gnt_idx0, gnt_valid0, 4'b0001, 0, 1);
        step();
        check("s3_regrant", gnt, gnt_idx, gnt_valid, 4'b0001, 0, 1);
        for (int c = 0; c < 20; c++) step();
        check("nolimit_long", gnt0, gnt_idx0, gnt_valid0, 4'b0001, 0, 1);
        drive(0, 4'b0000, 0);
        step();
        check("nolimit_release", gnt0, gnt_idx0, gnt_valid0, 4'b0000, 0, 0);

        // Mid-grant reset: move ptr to 3 first, so a stale ptr would pick 3.
        drive(1, 4'b0000, 0);
        step();
        drive(0, 4'b0100, 0);
        step();
        check("s5_first_g2", gnt, gnt_idx, gnt_valid, 4'b0100, 2, 1);
        drive(0, 4'b0000, 0);
        step();
        drive(0, 4'b0100, 0);
        step();
        check("s5_g2_ptr3", gnt, gnt_idx, gnt_valid, 4'b0100, 2, 1);
        drive(1, 4'b1100, 0);
        step();
        check("s5_reset_drop", gnt, gnt_idx, gnt_valid, 4'b0000, 0, 0);
        drive(0, 4'b1100, 0);
        step();
        check("s5_ptr0_after_reset", gnt, gnt_idx, gnt_valid, 4'b0100, 2, 1);
        drive(0, 4'b1100, 1);
        step();
        check("s5_release", gnt, gnt_idx, gnt_valid, 4'b0000, 0, 0);
        drive(0, 4'b1100, 0);
        step();
        check("s5_next_g3", gnt, gnt_idx, gnt_valid, 4'b1000, 3, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_rr_arbiter4
